// File: rtl/lif_update_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module   : lif_update_scheduler_if
// Brief    : Config / step / spike / monitor bundle for the LIF scheduler.
// Revision : 1.0
// ============================================================================
interface lif_update_scheduler_if #(
    parameter int N_NEURONS = 4,
    parameter int WIDTH     = 8
) ();
    logic                  cfg_we;
    logic [2:0]            cfg_addr;
    logic [WIDTH-1:0]      cfg_data;
    logic                  step;
    logic                  busy;
    logic                  done;
    logic [N_NEURONS-1:0]  spikes;
    logic [2:0]            mon_sel;
    logic [WIDTH-1:0]      mon_v;

    modport master (
        output cfg_we, cfg_addr, cfg_data, step, mon_sel,
        input  busy, done, spikes, mon_v
    );

    modport slave (
        input  cfg_we, cfg_addr, cfg_data, step, mon_sel,
        output busy, done, spikes, mon_v
    );
endinterface
`default_nettype wire

// File: rtl/lif_update_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : lif_update_scheduler
// Brief    : Time-steps N_NEURONS LIF neurons through one shared update datapath.
// Revision : 1.0
// ============================================================================
module lif_update_scheduler #(
    parameter int N_NEURONS  = 4,
    parameter int WIDTH      = 8,
    parameter int THRESH_RST = 100,
    parameter int LEAK_RST   = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    lif_update_scheduler_if.slave   bus
);

    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_FETCH  = 2'd1;
    localparam logic [1:0] c_ST_UPDATE = 2'd2;
    localparam logic [1:0] c_ST_DONE   = 2'd3;

    localparam logic [2:0] c_ADDR_THR  = 3'(N_NEURONS);
    localparam logic [2:0] c_ADDR_LEAK = 3'(N_NEURONS + 1);
    localparam logic [2:0] c_IDX_LAST  = 3'(N_NEURONS - 1);

    logic [1:0]           r_state;
    logic [2:0]           r_idx;
    logic [WIDTH-1:0]     r_pot [N_NEURONS];
    logic [WIDTH-1:0]     r_cur [N_NEURONS];
    logic [WIDTH-1:0]     r_thresh;
    logic [2:0]           r_shift;
    logic [WIDTH-1:0]     r_v;
    logic [WIDTH-1:0]     r_i;
    logic [N_NEURONS-1:0] r_spk_acc;
    logic [N_NEURONS-1:0] r_spikes;

    logic [WIDTH-1:0]     w_fetch_v;
    logic [WIDTH-1:0]     w_fetch_i;
    logic [WIDTH-1:0]     w_mon;
    logic [WIDTH-1:0]     w_leak;
    logic [WIDTH-1:0]     w_decayed;
    logic [WIDTH:0]       w_sum;
    logic [WIDTH-1:0]     w_sat;
    logic                 w_spike;
    logic [N_NEURONS-1:0] w_spk_next;
    logic                 w_cfg_ok;

    // Index-compare muxes keep the 3-bit index/select away from array bounds.
    always_comb begin
        w_fetch_v = '0;
        w_fetch_i = '0;
        w_mon     = '0;
        for (int n = 0; n < N_NEURONS; n++) begin
            if (r_idx == 3'(n)) begin
                w_fetch_v = r_pot[n];
                w_fetch_i = r_cur[n];
            end
            if (bus.mon_sel == 3'(n)) begin
                w_mon = r_pot[n];
            end
        end
    end

    // A zero shift means "no leak", not "leak everything".
    assign w_leak    = (r_shift == 3'd0) ? '0 : (r_v >> r_shift);
    assign w_decayed = r_v - w_leak;
    assign w_sum     = {1'b0, w_decayed} + {1'b0, r_i};
    assign w_sat     = w_sum[WIDTH] ? '1 : w_sum[WIDTH-1:0];
    assign w_spike   = (w_sat >= r_thresh);

    always_comb begin
        w_spk_next = r_spk_acc;
        for (int n = 0; n < N_NEURONS; n++) begin
            if (r_idx == 3'(n)) begin
                w_spk_next[n] = w_spike;
            end
        end
    end

    assign w_cfg_ok = bus.cfg_we && (r_state == c_ST_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= c_ST_IDLE;
            r_idx     <= '0;
            r_v       <= '0;
            r_i       <= '0;
            r_spk_acc <= '0;
            r_spikes  <= '0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (bus.step) begin
                        r_state   <= c_ST_FETCH;
                        r_idx     <= '0;
                        r_spk_acc <= '0;
                    end
                end
                c_ST_FETCH: begin
                    r_v     <= w_fetch_v;
                    r_i     <= w_fetch_i;
                    r_state <= c_ST_UPDATE;
                end
                c_ST_UPDATE: begin
                    r_spk_acc <= w_spk_next;
                    if (r_idx == c_IDX_LAST) begin
                        // Publish on entry to DONE so the vector is visible alongside done.
                        r_spikes <= w_spk_next;
                        r_state  <= c_ST_DONE;
                    end else begin
                        r_idx   <= r_idx + 3'd1;
                        r_state <= c_ST_FETCH;
                    end
                end
                c_ST_DONE: begin
                    r_state <= c_ST_IDLE;
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int n = 0; n < N_NEURONS; n++) begin
                r_pot[n] <= '0;
                r_cur[n] <= '0;
            end
            r_thresh <= WIDTH'(THRESH_RST);
            r_shift  <= 3'(LEAK_RST);
        end else begin
            if (w_cfg_ok) begin
                for (int n = 0; n < N_NEURONS; n++) begin
                    if (bus.cfg_addr == 3'(n)) begin
                        r_cur[n] <= bus.cfg_data;
                    end
                end
                if (bus.cfg_addr == c_ADDR_THR) begin
                    r_thresh <= bus.cfg_data;
                end
                if (bus.cfg_addr == c_ADDR_LEAK) begin
                    r_shift <= bus.cfg_data[2:0];
                end
            end
            if (r_state == c_ST_UPDATE) begin
                for (int n = 0; n < N_NEURONS; n++) begin
                    if (r_idx == 3'(n)) begin
                        r_pot[n] <= w_spike ? '0 : w_sat;
                    end
                end
            end
        end
    end

    assign bus.busy   = (r_state != c_ST_IDLE);
    assign bus.done   = (r_state == c_ST_DONE);
    assign bus.spikes = r_spikes;
    assign bus.mon_v  = w_mon;

endmodule
`default_nettype wire

// File: tb/tb_lif_update_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_lif_update_scheduler
// Brief    : Directed, table-driven self-checking bench for lif_update_scheduler.
// Revision : 1.0
// ============================================================================
module tb_lif_update_scheduler;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    lif_update_scheduler_if #(.N_NEURONS(4), .WIDTH(8)) bus ();

    lif_update_scheduler #(
        .N_NEURONS (4),
        .WIDTH     (8),
        .THRESH_RST(100),
        .LEAK_RST  (3)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic       we;
        logic [2:0] addr;
        logic [7:0] data;
        logic [2:0] sel;
        logic [3:0] exp_spk;
        logic [7:0] exp_mon;
    } vec_t;

    vec_t tbl [6];
    int   n_pass  = 0;
    int   n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Called at a negedge in IDLE; writes land on the following posedge.
    task automatic cfg_write(input logic [2:0] addr, input logic [7:0] data);
        bus.cfg_we   = 1'b1;
        bus.cfg_addr = addr;
        bus.cfg_data = data;
        @(negedge clk);
        bus.cfg_we   = 1'b0;
    endtask

    // Pulses step, returns cycles from the sampling edge to done and the spikes
    // seen in the done cycle, then leaves one more cycle so the FSM is in IDLE.
    task automatic do_step(output int lat, output logic [3:0] spk);
        lat = 0;
        spk = '0;
        bus.step = 1'b1;
        @(negedge clk);
        bus.step = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            if (bus.done) begin
                lat = c;
                spk = bus.spikes;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
    endtask

    initial begin
        int         lat;
        logic [3:0] spk;
        logic [11:0] bmask;
        int         dcnt;
        int         dcyc;
        int         first;
        int         second;

        tbl[0] = '{we:1'b1, addr:3'd0, data:8'd40,  sel:3'd0, exp_spk:4'b0000, exp_mon:8'd40};
        tbl[1] = '{we:1'b0, addr:3'd0, data:8'd0,   sel:3'd0, exp_spk:4'b0000, exp_mon:8'd75};
        tbl[2] = '{we:1'b0, addr:3'd0, data:8'd0,   sel:3'd0, exp_spk:4'b0001, exp_mon:8'd0};
        tbl[3] = '{we:1'b1, addr:3'd3, data:8'd120, sel:3'd3, exp_spk:4'b1000, exp_mon:8'd0};
        tbl[4] = '{we:1'b1, addr:3'd5, data:8'd1,   sel:3'd0, exp_spk:4'b1000, exp_mon:8'd60};
        tbl[5] = '{we:1'b1, addr:3'd4, data:8'd0,   sel:3'd1, exp_spk:4'b1111, exp_mon:8'd0};

        rst          = 1'b1;
        bus.cfg_we   = 1'b0;
        bus.cfg_addr = '0;
        bus.cfg_data = '0;
        bus.step     = 1'b0;
        bus.mon_sel  = '0;
        repeat (3) @(negedge clk);

        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_done", 32'(bus.done), 0);
        chk("rst_spikes", 32'(bus.spikes), 0);
        for (int s = 0; s < 8; s++) begin
            bus.mon_sel = 3'(s);
            #1;
            chk($sformatf("rst_mon%0d", s), 32'(bus.mon_v), 0);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        for (int k = 0; k < 6; k++) begin
            if (tbl[k].we) cfg_write(tbl[k].addr, tbl[k].data);
            do_step(lat, spk);
            bus.mon_sel = tbl[k].sel;
            #1;
            chk($sformatf("tbl%0d_lat", k), 32'(lat), 9);
            chk($sformatf("tbl%0d_spikes", k), 32'(spk), 32'(tbl[k].exp_spk));
            chk($sformatf("tbl%0d_mon", k), 32'(bus.mon_v), 32'(tbl[k].exp_mon));
            @(negedge clk);
        end

        // Latency and busy/done shape for one timestep.
        chk("lat_idle_busy", 32'(bus.busy), 0);
        bmask = '0;
        dcnt  = 0;
        dcyc  = 0;
        bus.step = 1'b1;
        @(negedge clk);
        bus.step = 1'b0;
        for (int c = 1; c <= 11; c++) begin
            if (bus.busy) bmask[c] = 1'b1;
            if (bus.done) begin
                dcnt++;
                dcyc = c;
            end
            @(negedge clk);
        end
        chk("lat_busy_mask", 32'(bmask), 32'h3FE);
        chk("lat_done_count", 32'(dcnt), 1);
        chk("lat_done_cycle", 32'(dcyc), 9);

        // Held step: consecutive timesteps are 2N+2 cycles apart.
        first  = 0;
        second = 0;
        bus.step = 1'b1;
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            if (bus.done) begin
                if (first == 0) first = c;
                else if (second == 0) second = c;
            end
        end
        bus.step = 1'b0;
        chk("b2b_period", 32'(second - first), 10);
        for (int c = 0; c < 30; c++) begin
            if (!bus.busy) break;
            @(negedge clk);
        end
        chk("b2b_idle", 32'(bus.busy), 0);

        // Saturation with leak disabled.
        do_reset();
        cfg_write(3'd4, 8'd255);
        cfg_write(3'd5, 8'd0);
        cfg_write(3'd1, 8'd200);
        bus.mon_sel = 3'd1;
        do_step(lat, spk);
        chk("sat1_spikes", 32'(spk), 0);
        chk("sat1_mon", 32'(bus.mon_v), 200);
        do_step(lat, spk);
        chk("sat2_spikes", 32'(spk), 32'b0010);
        chk("sat2_mon", 32'(bus.mon_v), 0);
        repeat (3) @(negedge clk);
        chk("sat_spikes_hold", 32'(bus.spikes), 32'b0010);

        // Config write and step while busy are dropped; addr 7 is ignored.
        do_reset();
        dcnt = 0;
        bus.step = 1'b1;
        @(negedge clk);
        bus.step = 1'b0;
        @(negedge clk);
        @(negedge clk);
        bus.cfg_we   = 1'b1;
        bus.cfg_addr = 3'd2;
        bus.cfg_data = 8'd50;
        bus.step     = 1'b1;
        @(negedge clk);
        bus.cfg_we   = 1'b0;
        bus.step     = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (bus.done) dcnt++;
            @(negedge clk);
        end
        chk("busy_done_count", 32'(dcnt), 1);
        chk("busy_idle", 32'(bus.busy), 0);
        cfg_write(3'd7, 8'd0);
        bus.mon_sel = 3'd2;
        do_step(lat, spk);
        chk("busy_cur2", 32'(bus.mon_v), 0);
        chk("addr7_spikes", 32'(spk), 0);

        // Reset in the middle of a timestep.
        do_reset();
        cfg_write(3'd4, 8'd255);
        cfg_write(3'd0, 8'd40);
        bus.mon_sel = 3'd0;
        do_step(lat, spk);
        chk("mid_pre_mon", 32'(bus.mon_v), 40);
        bus.step = 1'b1;
        @(negedge clk);
        bus.step = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_busy", 32'(bus.busy), 0);
        chk("mid_done", 32'(bus.done), 0);
        chk("mid_mon", 32'(bus.mon_v), 0);
        rst  = 1'b0;
        dcnt = 0;
        for (int c = 0; c < 10; c++) begin
            if (bus.done) dcnt++;
            @(negedge clk);
        end
        chk("mid_no_done", 32'(dcnt), 0);
        cfg_write(3'd0, 8'd100);
        do_step(lat, spk);
        chk("mid_thresh_spikes", 32'(spk), 32'b0001);
        chk("mid_post_mon", 32'(bus.mon_v), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
